// File: rtl/acq_fifo_writer.sv
// acq_fifo_writer: after a synchronised start, drops SKIP_LEN settling samples, then writes DLEN ADC samples into the FIFO.
module acq_fifo_writer #(
    parameter int DATA_W       = 16,
    parameter int SYNC_REG_LEN = 2,
    parameter int SKIP_LEN     = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ASYNC_START,
    input  logic [31:0]       DLEN,
    input  logic [DATA_W-1:0] ADC_DATA,
    input  logic              ADC_VALID,
    input  logic              FIFO_AFULL,
    output logic              FIFO_WREN,
    output logic [DATA_W-1:0] FIFO_WDATA,
    output logic              DONE,
    output logic              BUSY,
    output logic              OVERFLOW,
    output logic [31:0]       WR_CNT
);
    localparam logic [1:0] IDLE = 2'd0, SKIP = 2'd1, WRITE = 2'd2, FIN = 2'd3;
    localparam logic [31:0] SKIP_LAST = SKIP_LEN > 0 ? 32'(SKIP_LEN - 1) : 32'd0;
    logic [SYNC_REG_LEN-1:0] sync_q;
    logic [31:0] dlen_meta_q, dlen_r_q;
    logic [1:0] state_q, state_d;
    logic token_q, token_d, wren_q, wren_d, done_q, done_d, busy_q, busy_d, ovf_q, ovf_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [31:0] len_q, len_d, wr_cnt_q, wr_cnt_d, skip_cnt_q, skip_cnt_d;
    logic sync_start;
    assign sync_start = sync_q[SYNC_REG_LEN-1];
    assign FIFO_WREN  = wren_q;
    assign FIFO_WDATA = wdata_q;
    assign DONE       = done_q;
    assign BUSY       = busy_q;
    assign OVERFLOW   = ovf_q;
    assign WR_CNT     = wr_cnt_q;
    always_comb begin
        state_d    = state_q;
        token_d    = token_q;
        len_d      = len_q;
        wr_cnt_d   = wr_cnt_q;
        ovf_d      = ovf_q;
        done_d     = done_q;
        busy_d     = busy_q;
        skip_cnt_d = skip_cnt_q;
        wren_d     = 1'b0;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                // TOKEN freezes outside IDLE so a start still held on return cannot retrigger
                token_d = sync_start;
                if (sync_start && !token_q) begin
                    len_d      = dlen_r_q;
                    wr_cnt_d   = 32'd0;
                    ovf_d      = 1'b0;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    skip_cnt_d = 32'd0;
                    state_d    = dlen_r_q == 32'd0 ? FIN : (SKIP_LEN > 0 ? SKIP : WRITE);
                end
            end
            SKIP: if (ADC_VALID) begin
                skip_cnt_d = skip_cnt_q + 32'd1;
                state_d    = skip_cnt_q == SKIP_LAST ? WRITE : SKIP;
            end
            WRITE: begin
                if (ADC_VALID && !FIFO_AFULL) begin
                    wren_d   = 1'b1;
                    wdata_d  = ADC_DATA;
                    wr_cnt_d = wr_cnt_q + 32'd1;
                    state_d  = wr_cnt_q + 32'd1 == len_q ? FIN : WRITE;
                end else if (ADC_VALID) begin
                    ovf_d = 1'b1;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q      <= '0;
            dlen_meta_q <= '0;
            dlen_r_q    <= '0;
            state_q     <= IDLE;
            token_q     <= 1'b0;
            len_q       <= '0;
            wr_cnt_q    <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            skip_cnt_q  <= '0;
            wren_q      <= 1'b0;
            wdata_q     <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_REG_LEN-2:0], ASYNC_START};
            dlen_meta_q <= DLEN;
            dlen_r_q    <= dlen_meta_q;
            state_q     <= state_d;
            token_q     <= token_d;
            len_q       <= len_d;
            wr_cnt_q    <= wr_cnt_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            skip_cnt_q  <= skip_cnt_d;
            wren_q      <= wren_d;
            wdata_q     <= wdata_d;
        end
    end
endmodule

// File: tb/tb_acq_fifo_writer.sv
// tb_acq_fifo_writer: directed scenarios for the acquisition FIFO writer with SKIP_LEN=2.
module tb_acq_fifo_writer;
    logic CLK = 1'b0, RST = 1'b1, ASYNC_START = 1'b0, ADC_VALID = 1'b0, FIFO_AFULL = 1'b0;
    logic [31:0] DLEN = 32'd0;
    logic [15:0] ADC_DATA = 16'd0;
    logic FIFO_WREN, DONE, BUSY, OVERFLOW;
    logic [15:0] FIFO_WDATA;
    logic [31:0] WR_CNT;
    int vecs = 0, errs = 0, cyc = 0, done_rise = -1, done_lo = 0, busy_hi = 0;
    bit done_prev = 1'b1;
    logic [15:0] wq[$];
    int wc[$];

    acq_fifo_writer #(.DATA_W(16), .SYNC_REG_LEN(2), .SKIP_LEN(2)) dut (
        .CLK(CLK), .RST(RST), .ASYNC_START(ASYNC_START), .DLEN(DLEN), .ADC_DATA(ADC_DATA),
        .ADC_VALID(ADC_VALID), .FIFO_AFULL(FIFO_AFULL), .FIFO_WREN(FIFO_WREN), .FIFO_WDATA(FIFO_WDATA),
        .DONE(DONE), .BUSY(BUSY), .OVERFLOW(OVERFLOW), .WR_CNT(WR_CNT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) begin
        if (FIFO_WREN) begin
            wq.push_back(FIFO_WDATA);
            wc.push_back(cyc);
        end
        if (DONE && !done_prev) done_rise = cyc;
        done_prev = DONE;
        if (!DONE) done_lo++;
        if (BUSY) busy_hi++;
    end

    task automatic clear_obs();
        wq.delete();
        wc.delete();
        done_lo = 0;
        busy_hi = 0;
        done_rise = -1;
    endtask

    // Beat b carries data b; beats af_lo..af_lo+af_n-1 see FIFO_AFULL; hold keeps START high with a re-pulse mid-run
    task automatic drive_run(input int period, input int af_lo, input int af_n, input bit hold, output bit tmo);
        int b = 0;
        bit seen = 1'b0;
        tmo = 1'b1;
        @(negedge CLK) ASYNC_START = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            seen = BUSY;
        end
        if (!seen) return;
        DLEN = 32'd1;
        if (!hold) ASYNC_START = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!BUSY) begin
                tmo = 1'b0;
                break;
            end
            if (hold && c == 3) ASYNC_START = 1'b0;
            if (hold && c == 4) ASYNC_START = 1'b1;
            ADC_VALID = (c % period) == 0;
            FIFO_AFULL = ADC_VALID && b >= af_lo && b < af_lo + af_n;
            ADC_DATA = ADC_VALID ? 16'(b) : 16'hdead;
            if (ADC_VALID) b++;
            @(negedge CLK);
        end
        ADC_VALID = 1'b0;
        FIFO_AFULL = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        vecs++; if (FIFO_WREN !== 1'b0) begin errs++; $display("FAIL rst_wren got %b want 0", FIFO_WREN); end
        vecs++; if (FIFO_WDATA !== 16'd0) begin errs++; $display("FAIL rst_wdata got %h want 0", FIFO_WDATA); end
        vecs++; if (DONE !== 1'b1) begin errs++; $display("FAIL rst_done got %b want 1", DONE); end
        vecs++; if (BUSY !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", BUSY); end
        vecs++; if (OVERFLOW !== 1'b0) begin errs++; $display("FAIL rst_ovf got %b want 0", OVERFLOW); end
        vecs++; if (WR_CNT !== 32'd0) begin errs++; $display("FAIL rst_wrcnt got %0d want 0", WR_CNT); end
        RST = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_basic();
        logic [15:0] e [4] = '{16'd2, 16'd3, 16'd4, 16'd5};
        bit tmo;
        int last;
        DLEN = 32'd4;
        clear_obs();
        drive_run(1, 0, 0, 1'b0, tmo);
        repeat (2) @(negedge CLK);
        vecs++; if (tmo !== 1'b0) begin errs++; $display("FAIL basic_timeout got %b want 0", tmo); end
        vecs++; if (wq.size() != 4) begin errs++; $display("FAIL basic_nwr got %0d want 4", wq.size()); end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (i >= wq.size() || wq[i] !== e[i]) begin
                errs++; $display("FAIL basic_data[%0d] got %h want %h", i, i < wq.size() ? wq[i] : 16'hxxxx, e[i]);
            end
        end
        vecs++; if (wc.size() != 4 || wc[3] != wc[0] + 3) begin errs++; $display("FAIL basic_contig got %0d writes not back-to-back want 4 consecutive", wc.size()); end
        last = wc.size() > 0 ? wc[wc.size()-1] : -10;
        vecs++; if (done_rise != last + 1) begin errs++; $display("FAIL basic_done_rise got cyc %0d want %0d", done_rise, last + 1); end
        vecs++; if (WR_CNT !== 32'd4) begin errs++; $display("FAIL basic_wrcnt got %0d want 4", WR_CNT); end
        vecs++; if (OVERFLOW !== 1'b0) begin errs++; $display("FAIL basic_ovf got %b want 0", OVERFLOW); end
        vecs++; if (BUSY !== 1'b0 || DONE !== 1'b1) begin errs++; $display("FAIL basic_idle got busy %b done %b want 0 1", BUSY, DONE); end
    endtask

    task automatic test_backpressure();
        logic [15:0] e [8] = '{16'd2, 16'd3, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12};
        bit tmo;
        DLEN = 32'd8;
        clear_obs();
        drive_run(1, 4, 3, 1'b0, tmo);
        repeat (2) @(negedge CLK);
        vecs++; if (tmo !== 1'b0) begin errs++; $display("FAIL bp_timeout got %b want 0", tmo); end
        vecs++; if (wq.size() != 8) begin errs++; $display("FAIL bp_nwr got %0d want 8", wq.size()); end
        for (int i = 0; i < 8; i++) begin
            vecs++;
            if (i >= wq.size() || wq[i] !== e[i]) begin
                errs++; $display("FAIL bp_data[%0d] got %h want %h", i, i < wq.size() ? wq[i] : 16'hxxxx, e[i]);
            end
        end
        vecs++; if (OVERFLOW !== 1'b1) begin errs++; $display("FAIL bp_ovf got %b want 1", OVERFLOW); end
        vecs++; if (WR_CNT !== 32'd8) begin errs++; $display("FAIL bp_wrcnt got %0d want 8", WR_CNT); end
    endtask

    task automatic test_zero_len();
        bit tmo;
        DLEN = 32'd0;
        repeat (3) @(negedge CLK);
        clear_obs();
        drive_run(1, 0, 0, 1'b0, tmo);
        repeat (3) @(negedge CLK);
        vecs++; if (tmo !== 1'b0) begin errs++; $display("FAIL zero_timeout got %b want 0", tmo); end
        vecs++; if (wq.size() != 0) begin errs++; $display("FAIL zero_nwr got %0d want 0", wq.size()); end
        vecs++; if (done_lo != 1) begin errs++; $display("FAIL zero_done_low got %0d cycles want 1", done_lo); end
        vecs++; if (busy_hi != 1) begin errs++; $display("FAIL zero_busy_high got %0d cycles want 1", busy_hi); end
        vecs++; if (WR_CNT !== 32'd0) begin errs++; $display("FAIL zero_wrcnt got %0d want 0", WR_CNT); end
    endtask

    task automatic test_sparse_valid();
        logic [15:0] e [5] = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        bit tmo;
        DLEN = 32'd5;
        repeat (3) @(negedge CLK);
        clear_obs();
        drive_run(3, 0, 0, 1'b0, tmo);
        repeat (2) @(negedge CLK);
        vecs++; if (tmo !== 1'b0) begin errs++; $display("FAIL sparse_timeout got %b want 0", tmo); end
        vecs++; if (wq.size() != 5) begin errs++; $display("FAIL sparse_nwr got %0d want 5", wq.size()); end
        for (int i = 0; i < 5; i++) begin
            vecs++;
            if (i >= wq.size() || wq[i] !== e[i]) begin
                errs++; $display("FAIL sparse_data[%0d] got %h want %h", i, i < wq.size() ? wq[i] : 16'hxxxx, e[i]);
            end
        end
        for (int i = 1; i < 5 && i < wc.size(); i++) begin
            vecs++; if (wc[i] - wc[i-1] != 3) begin errs++; $display("FAIL sparse_gap[%0d] got %0d want 3", i, wc[i] - wc[i-1]); end
        end
        vecs++; if (WR_CNT !== 32'd5) begin errs++; $display("FAIL sparse_wrcnt got %0d want 5 (DLEN changed mid-run)", WR_CNT); end
    endtask

    task automatic test_start_held();
        bit tmo;
        DLEN = 32'd3;
        repeat (3) @(negedge CLK);
        clear_obs();
        drive_run(1, 2, 1, 1'b1, tmo);
        repeat (10) @(negedge CLK);
        vecs++; if (tmo !== 1'b0) begin errs++; $display("FAIL held_timeout got %b want 0", tmo); end
        vecs++; if (wq.size() != 3) begin errs++; $display("FAIL held_nwr got %0d want 3", wq.size()); end
        vecs++; if (wq.size() > 0 && wq[0] !== 16'd3) begin errs++; $display("FAIL held_first got %h want 3", wq[0]); end
        vecs++; if (BUSY !== 1'b0) begin errs++; $display("FAIL held_retrigger got busy %b want 0", BUSY); end
        vecs++; if (OVERFLOW !== 1'b1) begin errs++; $display("FAIL held_ovf got %b want 1", OVERFLOW); end
        ASYNC_START = 1'b0;
        DLEN = 32'd2;
        repeat (5) @(negedge CLK);
        clear_obs();
        drive_run(1, 0, 0, 1'b0, tmo);
        repeat (2) @(negedge CLK);
        vecs++; if (tmo !== 1'b0) begin errs++; $display("FAIL rerun_timeout got %b want 0", tmo); end
        vecs++; if (OVERFLOW !== 1'b0) begin errs++; $display("FAIL rerun_ovf got %b want 0", OVERFLOW); end
        vecs++; if (WR_CNT !== 32'd2 || wq.size() != 2) begin errs++; $display("FAIL rerun_cnt got wr_cnt %0d writes %0d want 2 2", WR_CNT, wq.size()); end
    endtask

    task automatic test_reset_mid_run();
        bit tmo, hit = 1'b0, seen = 1'b0;
        int b = 0;
        DLEN = 32'd10;
        repeat (3) @(negedge CLK);
        clear_obs();
        @(negedge CLK) ASYNC_START = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            seen = BUSY;
        end
        ASYNC_START = 1'b0;
        for (int i = 0; i < 100 && seen; i++) begin
            if (WR_CNT == 32'd3) begin
                hit = 1'b1;
                break;
            end
            ADC_VALID = 1'b1;
            ADC_DATA = 16'(b);
            b++;
            @(negedge CLK);
        end
        vecs++; if (hit !== 1'b1) begin errs++; $display("FAIL midrst_reach got %b want 1 (WR_CNT=3 not reached)", hit); end
        vecs++; if (FIFO_WREN !== 1'b1) begin errs++; $display("FAIL midrst_pre_wren got %b want 1", FIFO_WREN); end
        RST = 1'b1;
        #1;
        vecs++; if (FIFO_WREN !== 1'b0) begin errs++; $display("FAIL midrst_wren got %b want 0", FIFO_WREN); end
        vecs++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin errs++; $display("FAIL midrst_status got done %b busy %b want 1 0", DONE, BUSY); end
        vecs++; if (WR_CNT !== 32'd0) begin errs++; $display("FAIL midrst_wrcnt got %0d want 0", WR_CNT); end
        ADC_VALID = 1'b0;
        @(negedge CLK) RST = 1'b0;
        DLEN = 32'd2;
        repeat (3) @(negedge CLK);
        clear_obs();
        drive_run(1, 0, 0, 1'b0, tmo);
        repeat (2) @(negedge CLK);
        vecs++; if (tmo !== 1'b0) begin errs++; $display("FAIL postrst_timeout got %b want 0", tmo); end
        vecs++; if (WR_CNT !== 32'd2 || wq.size() != 2) begin errs++; $display("FAIL postrst_cnt got wr_cnt %0d writes %0d want 2 2", WR_CNT, wq.size()); end
        vecs++; if (wq.size() == 2 && (wq[0] !== 16'd2 || wq[1] !== 16'd3)) begin errs++; $display("FAIL postrst_data got %h %h want 2 3", wq[0], wq[1]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_sparse_valid();
        test_start_held();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
